// File: rtl/bubsys_video_pkg.sv
// rtl/bubsys_video_pkg.sv - shared timing constants and helpers for the BubSys video path
//
// Purpose: default raster geometry, pixel divider values for the two pixel
// clock modes, and a counter-width helper used by the timing generator.
package bubsys_video_pkg;

    // Default raster geometry (pixels / lines, counted from 0).
    localparam int BV_H_TOTAL  = 384;
    localparam int BV_H_ACTIVE = 256;
    localparam int BV_HS_START = 296;
    localparam int BV_HS_WIDTH = 32;
    localparam int BV_V_TOTAL  = 264;
    localparam int BV_V_ACTIVE = 224;
    localparam int BV_VS_START = 240;
    localparam int BV_VS_WIDTH = 8;

    // Master-clock enables per pixel for an 18 MHz master clock.
    localparam int BV_PXDIV_9M = 2;
    localparam int BV_PXDIV_6M = 3;

    // Bits needed to hold 0..n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bubsys_video_cen_div.sv
// rtl/bubsys_video_cen_div.sv - master-clock to pixel-clock enable divider
//
// Purpose: phase counter running 0..PXDIV-1 while the master clock enable is
// active, decoding one positive-edge and one negative-edge pixel enable.
// Ports:
//   clk     master clock
//   rst     asynchronous active-high reset
//   cen_n   master clock enable, active low; phase frozen while high
//   pcen_n  pixel positive-edge enable, active low (phase 0)
//   ncen_n  pixel negative-edge enable, active low (phase PXDIV/2)
//   pxen    internal active-high copy of the positive-edge enable
module bubsys_video_cen_div
    import bubsys_video_pkg::*;
#(
    parameter int PXDIV = BV_PXDIV_6M
) (
    input  logic clk,
    input  logic rst,
    input  logic cen_n,
    output logic pcen_n,
    output logic ncen_n,
    output logic pxen
);

    localparam int PH_W = cnt_width(PXDIV);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PXDIV - 1);
    localparam logic [PH_W-1:0] PH_NEG  = PH_W'(PXDIV / 2);

    logic [PH_W-1:0] phase;
    logic            run;

    // Enables are combinational so they line up with the cycle they qualify;
    // reset forces them inactive even though phase already reads 0.
    assign run    = !cen_n && !rst;
    assign pxen   = run && (phase == '0);
    assign pcen_n = !pxen;
    assign ncen_n = !(run && (phase == PH_NEG));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else if (!cen_n) begin
            phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
        end
    end

endmodule

// File: rtl/bubsys_video_timing_gen.sv
// rtl/bubsys_video_timing_gen.sv - parametrised raster timing generator with raster-line IRQ
//
// Purpose: pixel enables, H/V counters, blanking/sync decode, flipped render
// counters, frame parity and a programmable raster-line interrupt.
// Ports:
//   i_EMU_MCLK / i_EMU_RST        master clock, asynchronous active-high reset
//   i_EMU_CLKCEN_n                master clock enable (active low), freezes all state when high
//   i_HFLIP / i_VFLIP             flip controls for o_FHCNT / o_FVCNT
//   i_IRQ_EN / i_IRQ_LINE         raster interrupt enable and target line
//   i_IRQ_ACK                     one-cycle interrupt acknowledge
//   o_PXPCEN_n / o_PXNCEN_n       pixel positive/negative-edge enables
//   o_HCNT / o_VCNT               raw counters
//   o_FHCNT / o_FVCNT             flip-applied counters
//   o_HBLANK_n / o_VBLANK_n       low outside the active area
//   o_HSYNC_n / o_VSYNC_n / o_CSYNC_n  syncs, active low
//   o_FRAME                       frame parity
//   o_LINE_IRQ_n                  raster interrupt request level, active low
module bubsys_video_timing_gen
    import bubsys_video_pkg::*;
#(
    parameter int PXDIV    = BV_PXDIV_6M,
    parameter int HCNT_W   = 9,
    parameter int VCNT_W   = 9,
    parameter int H_TOTAL  = BV_H_TOTAL,
    parameter int H_ACTIVE = BV_H_ACTIVE,
    parameter int HS_START = BV_HS_START,
    parameter int HS_WIDTH = BV_HS_WIDTH,
    parameter int V_TOTAL  = BV_V_TOTAL,
    parameter int V_ACTIVE = BV_V_ACTIVE,
    parameter int VS_START = BV_VS_START,
    parameter int VS_WIDTH = BV_VS_WIDTH
) (
    input  logic              i_EMU_MCLK,
    input  logic              i_EMU_RST,
    input  logic              i_EMU_CLKCEN_n,
    input  logic              i_HFLIP,
    input  logic              i_VFLIP,
    input  logic              i_IRQ_EN,
    input  logic [VCNT_W-1:0] i_IRQ_LINE,
    input  logic              i_IRQ_ACK,
    output logic              o_PXPCEN_n,
    output logic              o_PXNCEN_n,
    output logic [HCNT_W-1:0] o_HCNT,
    output logic [VCNT_W-1:0] o_VCNT,
    output logic [HCNT_W-1:0] o_FHCNT,
    output logic [VCNT_W-1:0] o_FVCNT,
    output logic              o_HBLANK_n,
    output logic              o_VBLANK_n,
    output logic              o_HSYNC_n,
    output logic              o_VSYNC_n,
    output logic              o_CSYNC_n,
    output logic              o_FRAME,
    output logic              o_LINE_IRQ_n
);

    // Decode limits carry one extra bit so an end position equal to 2**W
    // still compares correctly.
    localparam logic [HCNT_W-1:0] H_LAST     = HCNT_W'(H_TOTAL - 1);
    localparam logic [VCNT_W-1:0] V_LAST     = VCNT_W'(V_TOTAL - 1);
    localparam logic [HCNT_W-1:0] H_FLIP_TOP = HCNT_W'(H_ACTIVE - 1);
    localparam logic [VCNT_W-1:0] V_FLIP_TOP = VCNT_W'(V_ACTIVE - 1);
    localparam logic [HCNT_W:0]   H_ACT_X    = (HCNT_W + 1)'(H_ACTIVE);
    localparam logic [HCNT_W:0]   HS_BEG_X   = (HCNT_W + 1)'(HS_START);
    localparam logic [HCNT_W:0]   HS_END_X   = (HCNT_W + 1)'(HS_START + HS_WIDTH);
    localparam logic [VCNT_W:0]   V_ACT_X    = (VCNT_W + 1)'(V_ACTIVE);
    localparam logic [VCNT_W:0]   VS_BEG_X   = (VCNT_W + 1)'(VS_START);
    localparam logic [VCNT_W:0]   VS_END_X   = (VCNT_W + 1)'(VS_START + VS_WIDTH);

    logic              pxen;
    logic [HCNT_W-1:0] hcnt;
    logic [HCNT_W-1:0] h_next;
    logic [VCNT_W-1:0] vcnt;
    logic [VCNT_W-1:0] v_next;
    logic              h_wrap;
    logic              v_wrap;
    logic [HCNT_W:0]   h_next_x;
    logic [VCNT_W:0]   v_next_x;
    logic              hblank_n;
    logic              vblank_n;
    logic              hsync_n;
    logic              vsync_n;
    logic              frame;
    logic              irq_n;
    logic              irq_set;
    logic              h_in_act;
    logic              v_in_act;

    bubsys_video_cen_div #(
        .PXDIV (PXDIV)
    ) u_cen_div (
        .clk    (i_EMU_MCLK),
        .rst    (i_EMU_RST),
        .cen_n  (i_EMU_CLKCEN_n),
        .pcen_n (o_PXPCEN_n),
        .ncen_n (o_PXNCEN_n),
        .pxen   (pxen)
    );

    always_comb begin
        h_wrap   = (hcnt == H_LAST);
        v_wrap   = h_wrap && (vcnt == V_LAST);
        h_next   = h_wrap ? '0 : hcnt + 1'b1;
        v_next   = vcnt;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : vcnt + 1'b1;
        end
        h_next_x = {1'b0, h_next};
        v_next_x = {1'b0, v_next};
    end

    // A request can only be raised on the pixel that starts a new line, so
    // a target line outside 0..V_TOTAL-1 never matches v_next.
    assign irq_set = pxen && h_wrap && i_IRQ_EN && (v_next == i_IRQ_LINE);

    // Decoded flags are loaded from the next-state counts so they change on
    // the same edge as the counters themselves.
    always_ff @(posedge i_EMU_MCLK or posedge i_EMU_RST) begin
        if (i_EMU_RST) begin
            hcnt     <= '0;
            vcnt     <= '0;
            frame    <= 1'b0;
            hblank_n <= 1'b1;
            vblank_n <= 1'b1;
            hsync_n  <= 1'b1;
            vsync_n  <= 1'b1;
            irq_n    <= 1'b1;
        end else begin
            if (pxen) begin
                hcnt     <= h_next;
                vcnt     <= v_next;
                hblank_n <= (h_next_x < H_ACT_X);
                vblank_n <= (v_next_x < V_ACT_X);
                hsync_n  <= !((h_next_x >= HS_BEG_X) && (h_next_x < HS_END_X));
                vsync_n  <= !((v_next_x >= VS_BEG_X) && (v_next_x < VS_END_X));
                if (v_wrap) begin
                    frame <= !frame;
                end
            end
            // Ack is honoured even while the master clock enable is off.
            if (irq_set) begin
                irq_n <= 1'b0;
            end else if (i_IRQ_ACK) begin
                irq_n <= 1'b1;
            end
        end
    end

    // Flip mirrors only the visible region; blanking positions pass through.
    assign h_in_act = ({1'b0, hcnt} < H_ACT_X);
    assign v_in_act = ({1'b0, vcnt} < V_ACT_X);

    assign o_FHCNT      = (i_HFLIP && h_in_act) ? H_FLIP_TOP - hcnt : hcnt;
    assign o_FVCNT      = (i_VFLIP && v_in_act) ? V_FLIP_TOP - vcnt : vcnt;
    assign o_HCNT       = hcnt;
    assign o_VCNT       = vcnt;
    assign o_HBLANK_n   = hblank_n;
    assign o_VBLANK_n   = vblank_n;
    assign o_HSYNC_n    = hsync_n;
    assign o_VSYNC_n    = vsync_n;
    assign o_CSYNC_n    = hsync_n & vsync_n;
    assign o_FRAME      = frame;
    assign o_LINE_IRQ_n = irq_n;

endmodule

// File: tb/tb_bubsys_video_timing_gen.sv
// tb/tb_bubsys_video_timing_gen.sv - directed self-checking bench for bubsys_video_timing_gen
//
// Instance a uses the default geometry (enables, one full line, horizontal
// decode and flip). Instance b keeps the default vertical geometry but has a
// 16-pixel line and PXDIV=2 so whole frames stay short (vertical decode,
// frame parity, vertical flip, raster IRQ, reset and freeze).
module tb_bubsys_video_timing_gen;

    localparam int BUDGET = 20000;

    logic       clk;
    logic       rst;
    logic       clken_n;
    logic       hflip;
    logic       vflip;
    logic       irq_en;
    logic [8:0] irq_line;
    logic       irq_ack;

    logic       a_pcen_n, a_ncen_n, a_hblank_n, a_vblank_n, a_hsync_n, a_vsync_n, a_csync_n, a_frame, a_irq_n;
    logic [8:0] a_hcnt, a_vcnt, a_fhcnt, a_fvcnt;
    logic       b_pcen_n, b_ncen_n, b_hblank_n, b_vblank_n, b_hsync_n, b_vsync_n, b_csync_n, b_frame, b_irq_n;
    logic [8:0] b_hcnt, b_vcnt, b_fhcnt, b_fvcnt;

    int checks;
    int failures;
    int cyc;
    int c_line;
    bit irq_seen;

    bubsys_video_timing_gen u_dut_a (
        .i_EMU_MCLK     (clk),
        .i_EMU_RST      (rst),
        .i_EMU_CLKCEN_n (clken_n),
        .i_HFLIP        (hflip),
        .i_VFLIP        (vflip),
        .i_IRQ_EN       (irq_en),
        .i_IRQ_LINE     (irq_line),
        .i_IRQ_ACK      (irq_ack),
        .o_PXPCEN_n     (a_pcen_n),
        .o_PXNCEN_n     (a_ncen_n),
        .o_HCNT         (a_hcnt),
        .o_VCNT         (a_vcnt),
        .o_FHCNT        (a_fhcnt),
        .o_FVCNT        (a_fvcnt),
        .o_HBLANK_n     (a_hblank_n),
        .o_VBLANK_n     (a_vblank_n),
        .o_HSYNC_n      (a_hsync_n),
        .o_VSYNC_n      (a_vsync_n),
        .o_CSYNC_n      (a_csync_n),
        .o_FRAME        (a_frame),
        .o_LINE_IRQ_n   (a_irq_n)
    );

    bubsys_video_timing_gen #(
        .PXDIV    (2),
        .H_TOTAL  (16),
        .H_ACTIVE (8),
        .HS_START (10),
        .HS_WIDTH (4)
    ) u_dut_b (
        .i_EMU_MCLK     (clk),
        .i_EMU_RST      (rst),
        .i_EMU_CLKCEN_n (clken_n),
        .i_HFLIP        (hflip),
        .i_VFLIP        (vflip),
        .i_IRQ_EN       (irq_en),
        .i_IRQ_LINE     (irq_line),
        .i_IRQ_ACK      (irq_ack),
        .o_PXPCEN_n     (b_pcen_n),
        .o_PXNCEN_n     (b_ncen_n),
        .o_HCNT         (b_hcnt),
        .o_VCNT         (b_vcnt),
        .o_FHCNT        (b_fhcnt),
        .o_FVCNT        (b_fvcnt),
        .o_HBLANK_n     (b_hblank_n),
        .o_VBLANK_n     (b_vblank_n),
        .o_HSYNC_n      (b_hsync_n),
        .o_VSYNC_n      (b_vsync_n),
        .o_CSYNC_n      (b_csync_n),
        .o_FRAME        (b_frame),
        .o_LINE_IRQ_n   (b_irq_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        if (b_irq_n == 1'b0) irq_seen = 1'b1;
    endtask

    // Advance until the chosen instance shows (h, v) with its pixel enable
    // active, i.e. the next edge moves to the following pixel.
    task automatic goto_px(input bit sel, input int h, input int v, input string tag);
        int n;
        n = 0;
        while (n < BUDGET &&
               !(32'(sel ? b_hcnt : a_hcnt) == h &&
                 32'(sel ? b_vcnt : a_vcnt) == v &&
                 (sel ? b_pcen_n : a_pcen_n) == 1'b0)) begin
            step();
            n = n + 1;
        end
        chk({tag, "_reach"}, 32'(n < BUDGET), 32'd1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        irq_seen = 1'b0;
        rst      = 1'b1;
        clken_n  = 1'b0;
        hflip    = 1'b0;
        vflip    = 1'b0;
        irq_en   = 1'b0;
        irq_line = 9'd0;
        irq_ack  = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_pcen", 32'(a_pcen_n), 1);
        chk("rst_ncen", 32'(a_ncen_n), 1);
        chk("rst_hcnt", 32'(a_hcnt), 0);
        chk("rst_vcnt", 32'(a_vcnt), 0);
        chk("rst_blank", 32'({a_hblank_n, a_vblank_n}), 3);
        chk("rst_sync", 32'({a_hsync_n, a_vsync_n, a_csync_n}), 7);
        chk("rst_frame", 32'(a_frame), 0);
        chk("rst_irq", 32'(a_irq_n), 1);
        hflip = 1'b1;
        vflip = 1'b1;
        #1;
        chk("flip_h0", 32'(a_fhcnt), 255);
        chk("flip_v0", 32'(a_fvcnt), 223);
        hflip = 1'b0;
        vflip = 1'b0;

        // Pixel enables, PXDIV=3
        rst = 1'b0;
        #1;
        chk("cen_ph0_p", 32'(a_pcen_n), 0);
        chk("cen_ph0_n", 32'(a_ncen_n), 1);
        step();
        chk("cen_ph1_p", 32'(a_pcen_n), 1);
        chk("cen_ph1_n", 32'(a_ncen_n), 0);
        chk("cen_ph1_h", 32'(a_hcnt), 1);
        step();
        chk("cen_ph2", 32'({a_pcen_n, a_ncen_n}), 3);
        step();
        chk("cen_ph3_p", 32'(a_pcen_n), 0);
        chk("cen_ph3_h", 32'(a_hcnt), 1);

        // One line, default geometry
        goto_px(0, 255, 0, "a255");
        chk("hblank_255", 32'(a_hblank_n), 1);
        goto_px(0, 256, 0, "a256");
        chk("hblank_256", 32'(a_hblank_n), 0);
        goto_px(0, 295, 0, "a295");
        chk("hsync_295", 32'(a_hsync_n), 1);
        goto_px(0, 296, 0, "a296");
        chk("hsync_296", 32'(a_hsync_n), 0);
        goto_px(0, 300, 0, "a300");
        hflip = 1'b1;
        #1;
        chk("flip_h300", 32'(a_fhcnt), 300);
        hflip = 1'b0;
        goto_px(0, 327, 0, "a327");
        chk("hsync_327", 32'(a_hsync_n), 0);
        goto_px(0, 328, 0, "a328");
        chk("hsync_328", 32'(a_hsync_n), 1);
        goto_px(0, 383, 0, "a383");
        step();
        chk("wrap_v1", 32'(a_vcnt), 1);
        chk("wrap_h0", 32'(a_hcnt), 0);
        chk("wrap_hblank", 32'(a_hblank_n), 1);
        goto_px(0, 0, 1, "a_l1");
        c_line = cyc;
        hflip = 1'b1;
        vflip = 1'b1;
        #1;
        chk("flip_h0_l1", 32'(a_fhcnt), 255);
        chk("flip_v1", 32'(a_fvcnt), 222);
        hflip = 1'b0;
        vflip = 1'b0;
        goto_px(0, 0, 2, "a_l2");
        chk("line_len", 32'(cyc - c_line), 1152);

        // Frame, default vertical geometry (instance b)
        goto_px(1, 0, 223, "b223");
        chk("vblank_223", 32'(b_vblank_n), 1);
        goto_px(1, 0, 224, "b224");
        chk("vblank_224", 32'(b_vblank_n), 0);
        goto_px(1, 0, 239, "b239");
        chk("vsync_239", 32'(b_vsync_n), 1);
        goto_px(1, 0, 240, "b240");
        chk("vsync_240", 32'({b_hsync_n, b_vsync_n, b_csync_n}), 4);
        goto_px(1, 11, 240, "b240h");
        chk("csync_both", 32'({b_hsync_n, b_vsync_n, b_csync_n}), 0);
        goto_px(1, 0, 247, "b247");
        chk("vsync_247", 32'(b_vsync_n), 0);
        goto_px(1, 0, 248, "b248");
        chk("vsync_248", 32'({b_hsync_n, b_vsync_n, b_csync_n}), 7);
        goto_px(1, 11, 248, "b248h");
        chk("csync_h", 32'({b_hsync_n, b_vsync_n, b_csync_n}), 2);
        goto_px(1, 15, 263, "b263");
        chk("frame_pre", 32'(b_frame), 0);
        step();
        chk("frame_post", 32'(b_frame), 1);
        chk("frame_v0", 32'(b_vcnt), 0);
        goto_px(1, 0, 10, "b10");
        vflip = 1'b1;
        #1;
        chk("flip_v10", 32'(b_fvcnt), 213);
        vflip = 1'b0;

        // Raster IRQ
        irq_line = 9'd100;
        irq_en   = 1'b1;
        goto_px(1, 15, 99, "b99");
        chk("irq_before", 32'(b_irq_n), 1);
        step();
        chk("irq_set", 32'({b_irq_n, b_vcnt}), 100);
        irq_en = 1'b0;
        goto_px(1, 0, 120, "b120");
        chk("irq_hold", 32'(b_irq_n), 0);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("irq_ack", 32'(b_irq_n), 1);
        goto_px(1, 0, 230, "b230");
        vflip = 1'b1;
        #1;
        chk("flip_v230", 32'(b_fvcnt), 230);
        vflip = 1'b0;
        irq_en = 1'b1;
        goto_px(1, 15, 99, "b99b");
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("irq_set_wins", 32'(b_irq_n), 0);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("irq_ack2", 32'(b_irq_n), 1);
        irq_line = 9'd300;
        irq_seen = 1'b0;
        goto_px(1, 15, 263, "b263b");
        chk("irq_300", 32'(irq_seen), 0);
        irq_line = 9'd0;
        step();
        chk("irq_line0", 32'({b_irq_n, b_vcnt}), 0);
        chk("frame_3rd", 32'(b_frame), 1);

        // Asynchronous reset mid-frame with a pending request
        goto_px(1, 5, 150, "b150");
        chk("irq_pend", 32'(b_irq_n), 0);
        rst = 1'b1;
        #2;
        chk("arst_cnt", 32'({b_hcnt, b_vcnt}), 0);
        chk("arst_cen", 32'({b_pcen_n, b_ncen_n}), 3);
        chk("arst_flags", 32'({b_hblank_n, b_vblank_n, b_hsync_n, b_vsync_n, b_csync_n}), 31);
        chk("arst_frame_irq", 32'({b_frame, b_irq_n}), 1);
        chk("arst_a_hcnt", 32'(a_hcnt), 0);
        step();
        step();
        rst = 1'b0;

        // Freeze, with an ack landing while frozen
        irq_line = 9'd1;
        irq_en   = 1'b1;
        goto_px(1, 0, 1, "b_l1");
        chk("irq_l1", 32'(b_irq_n), 0);
        goto_px(1, 3, 1, "b3");
        clken_n = 1'b1;
        #1;
        chk("frz_cen", 32'({b_pcen_n, b_ncen_n}), 3);
        repeat (4) step();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        repeat (5) step();
        chk("frz_h", 32'(b_hcnt), 3);
        chk("frz_v", 32'(b_vcnt), 1);
        chk("frz_irq", 32'(b_irq_n), 1);
        clken_n = 1'b0;
        irq_en  = 1'b0;
        step();
        chk("frz_resume", 32'(b_hcnt), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bubsys_video_timing_gen.md
Name: bubsys_video_timing_gen

Overview:
- Parametrised raster timing generator for the BubSys video path.
- Derives pixel clock enables from the master clock and runs the H/V counters.
- Produces blanking, sync, composite sync, flipped render counters and a new programmable raster-line interrupt with request/acknowledge handshake.
- Replaces the fixed 9M/6M divider and sync logic; sits between the master-clock domain and the tilemap/sprite/palette engines.

Parameters:
PXDIV, 3, master-clock enables per pixel (>=2)
HCNT_W, 9, horizontal counter width
VCNT_W, 9, vertical counter width
H_TOTAL, 384, pixels per line
H_ACTIVE, 256, visible pixels per line (starting at hcnt 0)
HS_START, 296, hcnt where HSYNC asserts (H_ACTIVE <= HS_START, HS_START+HS_WIDTH <= H_TOTAL)
HS_WIDTH, 32, HSYNC width in pixels
V_TOTAL, 264, lines per frame
V_ACTIVE, 224, visible lines (starting at vcnt 0)
VS_START, 240, vcnt where VSYNC asserts (V_ACTIVE <= VS_START, VS_START+VS_WIDTH <= V_TOTAL)
VS_WIDTH, 8, VSYNC width in lines

Ports:
i_EMU_MCLK  in  1  master clock
i_EMU_RST  in  1  asynchronous active-high reset
i_EMU_CLKCEN_n  in  1  master clock enable, active low; all state frozen while high
i_HFLIP  in  1  horizontal flip
i_VFLIP  in  1  vertical flip
i_IRQ_EN  in  1  raster interrupt enable
i_IRQ_LINE  in  VCNT_W  interrupt target line
i_IRQ_ACK  in  1  interrupt acknowledge, one-cycle pulse
o_PXPCEN_n  out  1  pixel positive-edge enable, active low
o_PXNCEN_n  out  1  pixel negative-edge enable, active low
o_HCNT  out  HCNT_W  raw horizontal count
o_VCNT  out  VCNT_W  raw vertical count
o_FHCNT  out  HCNT_W  flip-applied horizontal count
o_FVCNT  out  VCNT_W  flip-applied vertical count
o_HBLANK_n  out  1  low outside the active width
o_VBLANK_n  out  1  low outside the active height
o_HSYNC_n  out  1  horizontal sync, active low
o_VSYNC_n  out  1  vertical sync, active low
o_CSYNC_n  out  1  composite sync
o_FRAME  out  1  frame parity
o_LINE_IRQ_n  out  1  raster interrupt request, active low level

Behaviour:
Reset:
- phase=0, hcnt=0, vcnt=0, FRAME=0.
- Both CEN outputs high; HBLANK_n=1, VBLANK_n=1, all syncs 1, LINE_IRQ_n=1.
- Asserting reset mid-frame returns to this state immediately (asynchronously).

Pixel clock enables:
- phase counts 0..PXDIV-1 on each cycle with i_EMU_CLKCEN_n=0, then wraps to 0.
- o_PXPCEN_n = 0 combinationally when phase==0 and CLKCEN active.
- o_PXNCEN_n = 0 when phase==PXDIV/2 (floor) and CLKCEN active.
- Example: PXDIV=3 gives PCEN at phase 0 and NCEN at phase 1.
- pxen is the internal PCEN pulse.

Counters:
- On pxen, hcnt increments; at H_TOTAL-1 it wraps to 0 and vcnt increments.
- vcnt wraps from V_TOTAL-1 to 0; FRAME toggles on that wrap.

Decoded outputs:
- Registered from next-state counters, so they change in the same cycle as o_HCNT/o_VCNT. Zero extra latency relative to the counters.
- HBLANK_n = hcnt < H_ACTIVE.
- VBLANK_n = vcnt < V_ACTIVE.
- HSYNC_n = 0 when HS_START <= hcnt < HS_START+HS_WIDTH.
- VSYNC_n = 0 when VS_START <= vcnt < VS_START+VS_WIDTH.
- CSYNC_n = HSYNC_n & VSYNC_n.

Flip:
- o_FHCNT = i_HFLIP ? H_ACTIVE-1-hcnt : hcnt, applied only when hcnt < H_ACTIVE; passes raw otherwise.
- o_FVCNT uses the same rule with V_ACTIVE and i_VFLIP.
- Combinational from the registered counts; the flip inputs take effect immediately.

Raster IRQ:
- Set (LINE_IRQ_n=0) on the pxen where hcnt wraps to 0, if i_IRQ_EN=1 and the new vcnt == i_IRQ_LINE.
- Wrap into line 0 counts as a new line.
- Cleared by i_IRQ_ACK.
- Set and ack in the same cycle: set wins.
- i_IRQ_EN=0 blocks new sets but does not clear a pending request.
- i_IRQ_LINE >= V_TOTAL never fires.

Freeze: when i_EMU_CLKCEN_n=1, nothing changes except IRQ clear on ack.

Decomposition:
- Shared package bubsys_video_pkg holds:
  - default timing constants (H_TOTAL, H_ACTIVE, sync positions, V_*);
  - PXDIV values for the 9M and 6M modes;
  - a counter-width helper function.
- One sub-module, bubsys_video_cen_div: phase counter plus PCEN/NCEN decode, reusable for the 9M enable.

Test Plan:
- Reset, then CLKCEN held low, PXDIV=3 -> PXPCEN_n low every 3rd cycle at phase 0; PXNCEN_n low one cycle later; period 3 cycles.
- Run one line with defaults:
  - HBLANK_n falls at hcnt=256;
  - HSYNC_n low for hcnt 296..327 (32 pixels);
  - line length 384 pxen;
  - vcnt 0->1 at hcnt wrap.
- Run full frame ->
  - VBLANK_n low at vcnt=224;
  - VSYNC_n low for lines 240..247;
  - CSYNC_n equals the AND of the two syncs;
  - FRAME toggles after 264 lines;
  - vcnt returns to 0.
- HFLIP=1, VFLIP=1:
  - hcnt=0 gives FHCNT=255;
  - hcnt=300 gives FHCNT=300;
  - vcnt=10 gives FVCNT=213.
- IRQ_EN=1, IRQ_LINE=100:
  - LINE_IRQ_n falls on the pxen entering vcnt=100, hcnt=0, and holds until ack;
  - ack coincident with the next set -> remains low;
  - IRQ_LINE=300 -> never fires.
- Assert reset at vcnt=150, hcnt=200, with IRQ pending -> all outputs return to reset values immediately; CLKCEN_n=1 for 10 cycles -> counters frozen.
